csrw_uart_tx: RTL
=================

Name: csrw_uart_tx

Overview:
- Downstream consumer of the processor's W-stage CSR output write (csrw out0 channel).
- Each 32-bit value written to the output CSR is captured into a small FIFO, then serialized off-chip as four UART 8N1 bytes, least-significant byte first.
- The processor never stalls on this block. Writes that arrive while the FIFO is full are dropped and counted.

Parameters:
- CLKS_PER_BIT, 16: clock cycles each UART bit is held; legal range is 2 or more.
- FIFO_DEPTH, 4: word entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- wen  in  1  CSR output write strobe (W-stage csrw out0 enable).
- wdata  in  32  value being written to out0.
- tx  out  1  UART serial line; idle is high.
- busy  out  1  high when the FIFO is non-empty or a frame is in progress.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_count  out  8  writes lost to overflow; saturates.

Behaviour:
- Reset values: tx=1, busy=0, full=0, count=0, drop_count=0. The FSM goes to IDLE and all counters and pointers clear.
- Reset asserted mid-frame aborts the frame. tx is high from the cycle after the reset edge, and FIFO contents are discarded.
- Enqueue:
  - wen && !full: wdata is written at the edge; count increments.
  - wen && full: no write; drop_count increments, holding at 255.
- Dequeue: happens in an IDLE cycle when count is nonzero. The head word loads into the 32-bit shift word, byte_idx is set to 0, and the FSM moves to START at the edge.
- Simultaneous push and pop in the same cycle:
  - Count is unchanged.
  - Push is accepted even if full was 1 that cycle, because the pop frees a slot.
  - Push into an empty FIFO cannot pop in the same cycle; the head is valid the next cycle.
- Latency: wen at cycle t with the FSM idle and the FIFO empty gives an entry at edge t+1, a pop in cycle t+1, and tx=0 (start bit) from cycle t+2.
- FSM states:
  - IDLE: tx=1.
  - START: tx=0, held CLKS_PER_BIT cycles.
  - DATA: tx = current byte bit[bit_idx], LSB first; 8 bits, each held CLKS_PER_BIT cycles.
  - STOP: tx=1, held CLKS_PER_BIT cycles. Then:
    - if byte_idx<3: byte_idx++ and go directly to START;
    - otherwise go to IDLE.
- Baud counter: runs 0..CLKS_PER_BIT-1 and wraps to 0 on every bit transition. bit_idx wraps 7 to 0 on the DATA-to-STOP transition.
- Word frame timing: exactly 40*CLKS_PER_BIT cycles from the first start bit to the end of the last stop bit.
- Back-to-back words: one IDLE cycle (tx=1) is inserted, so the gap between words is CLKS_PER_BIT+1 high cycles.
- tx is driven from a register, so it is glitch-free.
- busy = (state != IDLE) || (count != 0). full = (count == FIFO_DEPTH).
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. count is one bit wider so full and empty are distinguishable.

Decomposition:
- Shared package csrw_uart_pkg holds the FSM state enum (IDLE, START, DATA, STOP) and BYTES_PER_WORD=4.
- One sub-module, csrw_word_fifo, is parameterized by width and depth. It provides push, pop, rdata, full, empty and count, with synchronous active-high reset. The top level holds the FSM, baud counter, bit/byte indices, shift word and drop counter.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Single write 0x000000A5 at cycle 0 with idle FSM:
  - tx=0 over cycles 2-5;
  - data bits 1,0,1,0,0,1,0,1, four cycles each;
  - stop bit high;
  - bytes 1-3 each sent as start, eight zeros, stop;
  - busy falls after cycle 161.
- Write 0x12345678: the decoded byte stream is 0x78, 0x56, 0x34, 0x12, with no idle cycle between bytes.
- Six writes on consecutive cycles 0-5:
  - count reads 1,1,2,3,4 after edges 1-5;
  - full=1 at cycle 5, so write 6 is dropped and drop_count=1;
  - exactly 5 words are transmitted, in order.
- Full FIFO plus a write in the exact IDLE pop cycle: the write is accepted, count stays 4, drop_count is unchanged.
- 300 writes into a full FIFO with the line stalled mid-frame: drop_count saturates at 255 and never wraps.
- Assert rst during DATA of byte 2: tx=1 from the next cycle, count=0, busy=0, drop_count=0; a subsequent write transmits normally.

Source files
------------

// File: rtl/csrw_uart_pkg.sv
// csrw_uart_pkg
//   Shared definitions for the CSR-output UART transmitter: the transmit
//   FSM state encoding and the number of bytes serialized per CSR word.
package csrw_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/csrw_word_fifo.sv
// csrw_word_fifo
//   Small synchronous FIFO of WIDTH-bit words, DEPTH entries (power of 2).
//   A push while full is still accepted when a pop happens in the same
//   cycle, since the pop frees the slot. Read data is the current head.
// Ports:
//   clk, rst     clock, synchronous active-high reset (pointers/count only)
//   push, wdata  write strobe and word
//   pop          remove head word (ignored when empty)
//   rdata        head word, valid while !empty
//   full, empty  occupancy flags
//   count        occupancy, one bit wider than the pointers
module csrw_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign rdata     = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Pointers wrap naturally at DEPTH because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/csrw_uart_tx.sv
// csrw_uart_tx
//   Captures every CSR out0 write into a word FIFO and serializes each word
//   as four UART 8N1 bytes, least-significant byte first. The writer is
//   never stalled; writes that find the FIFO full are dropped and counted.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   wen, wdata   CSR out0 write strobe and 32-bit value
//   tx           registered UART line, idle high
//   busy         FIFO non-empty or a frame in progress
//   full         FIFO holds FIFO_DEPTH words
//   count        FIFO occupancy
//   drop_count   writes lost to overflow, saturating at 255
module csrw_uart_tx
    import csrw_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wen,
    input  logic [31:0]                   wdata,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic [7:0]                    drop_count
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]     BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    state_t                  r_state;
    logic [BAUD_W-1:0]       r_baud;
    logic [2:0]              r_bit_idx;
    logic [BYTE_IDX_W-1:0]   r_byte_idx;
    logic [31:0]             r_word;
    logic                    r_tx;
    logic [7:0]              r_drop;

    logic                    w_pop;
    logic                    w_push;
    logic                    w_full;
    logic                    w_empty;
    logic [31:0]             w_rdata;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic                    w_baud_done;
    logic [2:0]              w_next_bit_idx;

    // A pop frees a slot, so a write in the pop cycle is accepted even when full.
    assign w_pop          = (r_state == IDLE) && !w_empty;
    assign w_push         = wen && (!w_full || w_pop);
    assign w_baud_done    = (r_baud == BAUD_LAST);
    assign w_next_bit_idx = r_bit_idx + 3'd1;

    csrw_word_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata (wdata),
        .pop   (w_pop),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // r_tx is loaded with the value of the state being entered, so the line
    // changes exactly on the edge where the FSM changes state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_tx       <= 1'b1;
            r_drop     <= '0;
        end else begin
            if (wen && !w_push && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;

            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    if (w_pop) begin
                        r_byte_idx <= '0;
                        r_bit_idx  <= '0;
                        r_tx       <= 1'b0;
                        r_state    <= START;
                    end
                end
                START: begin
                    r_baud <= r_baud + BAUD_W'(1);
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_tx    <= r_word[{r_byte_idx, 3'd0}];
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    r_baud <= r_baud + BAUD_W'(1);
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
                            r_tx      <= 1'b1;
                            r_state   <= STOP;
                        end else begin
                            r_bit_idx <= w_next_bit_idx;
                            r_tx      <= r_word[{r_byte_idx, w_next_bit_idx}];
                        end
                    end
                end
                STOP: begin
                    r_baud <= r_baud + BAUD_W'(1);
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_byte_idx != LAST_BYTE) begin
                            r_byte_idx <= r_byte_idx + BYTE_IDX_W'(1);
                            r_tx       <= 1'b0;
                            r_state    <= START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) r_word <= w_rdata;
    end

    assign tx         = r_tx;
    assign busy       = (r_state != IDLE) || (w_count != '0);
    assign full       = w_full;
    assign count      = w_count;
    assign drop_count = r_drop;

endmodule
